// File: rtl/logic_seq_pkg.sv
// Shared encodings for the bit-serial logic sequencer: operation codes and FSM states.
package logic_seq_pkg;
  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/bitserial_logic_seq_blu.sv
// One-bit logic unit: four primitive gates followed by a 4:1 select on op.
module and_gate (input logic a, input logic b, output logic y);
  assign y = a & b;
endmodule

module or_gate (input logic a, input logic b, output logic y);
  assign y = a | b;
endmodule

module xor_gate (input logic a, input logic b, output logic y);
  assign y = a ^ b;
endmodule

module not_gate (input logic a, output logic y);
  assign y = ~a;
endmodule

module bit_logic_unit
  import logic_seq_pkg::*;
(
  input  logic [1:0] op,
  input  logic       x,
  input  logic       y,
  output logic       z
);
  logic w_and, w_or, w_xor, w_not;

  and_gate u_and (.a(x), .b(y), .y(w_and));
  or_gate  u_or  (.a(x), .b(y), .y(w_or));
  xor_gate u_xor (.a(x), .b(y), .y(w_xor));
  not_gate u_not (.a(x), .y(w_not));

  always_comb begin
    case (op)
      OP_AND:  z = w_and;
      OP_OR:   z = w_or;
      OP_XOR:  z = w_xor;
      default: z = w_not;
    endcase
  end
endmodule

// File: rtl/bitserial_logic_seq.sv
// Bit-serial sequencer: one WIDTH-bit AND/OR/XOR/NOT per handshake, one bit per clock, LSB first.
// Define BSEQ_BACK2BACK_EN to let DONE accept the next request in the same cycle as the pop.
module bitserial_logic_seq
  import logic_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_res_sh, r_result;
  logic             w_bit, w_accept;
  logic [WIDTH-1:0] w_res_next;

  bit_logic_unit u_blu (.op(r_op), .x(r_a[0]), .y(r_b[0]), .z(w_bit));

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_res_next = w_bit;
    end else begin : g_wn
      assign w_res_next = {w_bit, r_res_sh[WIDTH-1:1]};
    end
  endgenerate

`ifdef BSEQ_BACK2BACK_EN
  assign in_ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
`else
  assign in_ready = (r_state == ST_IDLE);
`endif
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  // r_result only moves when a new result completes, so it also holds the last delivered value
  assign result    = r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= OP_AND;
      r_a      <= '0;
      r_b      <= '0;
      r_res_sh <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= op;
      r_cnt   <= '0;
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_res_sh <= w_res_next;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_result <= w_res_next;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: if (out_ready) r_state <= ST_IDLE;
        ST_IDLE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitserial_logic_seq.sv
// Scoreboard bench for bitserial_logic_seq (WIDTH=8 main instance, WIDTH=1 corner instance).
module tb_bitserial_logic_seq;
  localparam int W = 8;
`ifdef BSEQ_BACK2BACK_EN
  localparam int PER = W + 1;
`else
  localparam int PER = W + 2;
`endif

  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 1;
  logic [1:0] op = 0;
  logic [W-1:0] a = 0, b = 0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] result;

  logic v1 = 0, ordy1 = 1;
  logic [1:0] op1 = 0;
  logic a1 = 0, b1 = 0;
  logic irdy1, ov1, busy1, res1;

  bitserial_logic_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy));

  bitserial_logic_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(irdy1), .op(op1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(ordy1), .result(res1), .busy(busy1));

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] exp; int acc; } item_t;
  item_t q[$];
  int rises[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic prev_ov = 0, prev_or = 0;
  logic [W-1:0] prev_res = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, y);
    case (o)
      2'd0: return x & y;
      2'd1: return x | y;
      2'd2: return x ^ y;
      default: return ~x;
    endcase
  endfunction

  // Monitor: latency on each rising out_valid, value on each pop, stability under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 0;
      prev_or = 0;
    end else begin
      if (out_valid && !prev_ov) begin
        rises.push_back(cyc);
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", cyc - q[0].acc, W);
      end
      if (out_valid && prev_ov && !prev_or) chk("hold_result", result, prev_res);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("pop_without_request", 1, 0);
        else begin
          item_t it;
          it = q.pop_front();
          chk("result", result, it.exp);
        end
      end
      prev_ov = out_valid;
      prev_or = out_ready;
      prev_res = result;
    end
  end

  // Hold the request until the DUT takes it; expected value goes into the scoreboard.
  task automatic send_exp(input logic [1:0] o, input logic [W-1:0] x, y, input logic [W-1:0] e);
    bit ok = 0;
    item_t it;
    op = o; a = x; b = y; in_valid = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      it.exp = e;
      it.acc = cyc + 1;
      q.push_back(it);
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] o, input logic [W-1:0] x, y);
    send_exp(o, x, y, model(o, x, y));
  endtask

  task automatic idle();
    in_valid = 0;
    op = 2'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state at power-up
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    @(posedge clk); #1 rst = 0;

    // Truth table with known constants
    out_ready = 1;
    send_exp(2'd0, 8'hCA, 8'h5C, 8'h48); idle(); drain();
    send_exp(2'd1, 8'hCA, 8'h5C, 8'hDE); idle(); drain();
    send_exp(2'd2, 8'hCA, 8'h5C, 8'h96); idle(); drain();
    send_exp(2'd3, 8'hCA, 8'h5C, 8'h35); idle(); drain();
    chk("result_held_after_pop", result, 8'h35);

    // Backpressure: result and in_ready stay put while out_ready is low
    out_ready = 0;
    send_exp(2'd2, 8'hFF, 8'h0F, 8'hF0); idle();
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, 8'hF0);
    end
    @(posedge clk); #1 out_ready = 1;
    drain();

    // Request during RUN is ignored, then taken once the DUT is ready
    send(2'd0, 8'hA5, 8'h3C); in_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("run_busy", busy, 1);
    chk("run_in_ready", in_ready, 0);
    @(posedge clk); #1;
    send(2'd1, 8'h12, 8'h40); idle(); drain();

    // Throughput: continuous requests with the consumer always ready
    rises.delete();
    send(2'd0, 8'h0F, 8'h3C);
    send(2'd1, 8'h81, 8'h18);
    send(2'd2, 8'hAA, 8'hFF);
    send(2'd3, 8'h5A, 8'h00);
    idle(); drain();
    chk("tput_count", rises.size(), 4);
    for (int i = 0; i + 1 < rises.size(); i++) chk("tput_period", rises[i+1] - rises[i], PER);

    // Randomized traffic with random consumer stalls
    begin
      bit rdone = 0;
      fork
        begin
          for (int i = 0; i < 25; i++) begin
            send(2'($urandom), W'($urandom), W'($urandom));
            if ($urandom_range(0, 1) == 0) begin idle(); repeat ($urandom_range(0, 3)) @(posedge clk); #1; end
          end
          idle();
          rdone = 1;
        end
        begin
          while (!rdone) begin
            @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
          end
        end
      join
      out_ready = 1;
      drain();
    end

    // Reset asserted mid-RUN aborts the operation
    send(2'd0, 8'hF0, 8'hFF); idle();
    repeat (3) @(posedge clk);
    #3 rst = 1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    q.delete();
    @(posedge clk); #1 rst = 0;

    // WIDTH=1: result one clock after acceptance
    ordy1 = 1; v1 = 1; op1 = 2'd1; a1 = 1; b1 = 0;
    @(negedge clk); chk("w1_in_ready", irdy1, 1);
    @(posedge clk); #1 v1 = 0;
    @(negedge clk); chk("w1_run_ov", ov1, 0);
    @(negedge clk); chk("w1_or_ov", ov1, 1); chk("w1_or_res", res1, 1);
    @(posedge clk); #1 v1 = 1; op1 = 2'd3; a1 = 1; b1 = 1;
    for (int i = 0; i < 5 && !irdy1; i++) @(negedge clk);
    @(negedge clk); chk("w1_not_rdy", irdy1, 1);
    @(posedge clk); #1 v1 = 0;
    @(negedge clk);
    @(negedge clk); chk("w1_not_ov", ov1, 1); chk("w1_not_res", res1, 0);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
